// File: rtl/inst_mem_pkg.sv
// ----------------------------------------------------------------------------
// inst_mem_pkg
//   Shared types for the instruction-memory responder.
//   - ADDR_W / INST_W : program-counter and instruction widths
//   - pc_t / inst_t   : address and instruction word types
//   - NOP_INST        : word returned for out-of-range fetches
//   - rsp_t           : one pipeline slot (valid, addr, inst, oob[, par_err])
//   - even_par()      : parity bit that makes {word, bit} carry an even count of ones
// Optional feature macro: INST_PARITY_EN adds the par_err field to rsp_t.
// ----------------------------------------------------------------------------
package inst_mem_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned INST_W = 9;

   typedef logic [INST_W-1:0] inst_t;
   typedef logic [ADDR_W-1:0] pc_t;

   localparam inst_t NOP_INST = '0;

   typedef struct packed {
      logic  valid;
      pc_t   addr;
      inst_t inst;
      logic  oob;
`ifdef INST_PARITY_EN
      logic  par_err;
`endif
   } rsp_t;

   function automatic logic even_par(input inst_t i_word);
      return ^i_word;
   endfunction

endpackage

// File: rtl/inst_mem_pipe.sv
// ----------------------------------------------------------------------------
// inst_mem_pipe
//   LATENCY-deep register chain carrying responses from the accept edge to the
//   output. Slot 0 is loaded at the accept edge; the last slot drives the
//   responder outputs directly, so all response outputs are registered.
//   Payload fields only move together with a valid bit, so the last slot keeps
//   the previous response's payload while no response is presented.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (clears every slot)
//   i_flush      drop every slot already in flight (slot 0 still takes i_stage_in)
//   i_stage_in   new response entering slot 0 (valid = accepted this cycle)
//   o_stage_out  contents of the last slot
// Optional feature macro: INST_PARITY_EN (only widens rsp_t).
// ----------------------------------------------------------------------------
module inst_mem_pipe
   import inst_mem_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_flush,
   input  rsp_t i_stage_in,
   output rsp_t o_stage_out
);

   rsp_t r_stage [LATENCY];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         // A request accepted together with a flush is the branch target: keep it.
         if (i_stage_in.valid) begin
            r_stage[0] <= i_stage_in;
         end else begin
            r_stage[0].valid <= 1'b0;
         end
         for (int i = 1; i < int'(LATENCY); i++) begin
            if (r_stage[i-1].valid && !i_flush) begin
               r_stage[i] <= r_stage[i-1];
            end else begin
               // Payload untouched so the output holds its last value.
               r_stage[i].valid <= 1'b0;
            end
         end
      end
   end

   assign o_stage_out = r_stage[LATENCY-1];

endmodule

// File: rtl/inst_mem_responder.sv
// ----------------------------------------------------------------------------
// inst_mem_responder
//   Instruction-memory responder for the fetch stage. Accepts one PC-driven
//   request per cycle and returns the stored instruction exactly LATENCY cycles
//   after the accept edge. A load port writes program images; a flush kills all
//   in-flight reads on a taken branch.
// Parameters:
//   DEPTH    implemented words; addresses >= DEPTH return NOP with o_rsp_oob=1
//   LATENCY  accept-to-response cycles, 1..4
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    fetch request present
//   o_req_ready    request can be accepted (low in reset and while i_load_en=1)
//   i_req_addr     requested program address
//   i_flush        discard all in-flight requests
//   o_rsp_valid    single-cycle pulse per response
//   o_rsp_inst     instruction word (held while o_rsp_valid=0)
//   o_rsp_addr     address the response belongs to (held while o_rsp_valid=0)
//   o_rsp_oob      response address was out of range (held while o_rsp_valid=0)
//   o_rsp_par_err  stored parity mismatch (INST_PARITY_EN builds only)
//   i_load_en      program-image write strobe
//   i_load_addr    write address (>= DEPTH ignored)
//   i_load_data    write data
// Optional feature macro: INST_PARITY_EN -- stores an even-parity bit per word
//   at load time, checks it on read and reports mismatches on o_rsp_par_err.
// ----------------------------------------------------------------------------
module inst_mem_responder
   import inst_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_flush,
   output logic              o_rsp_valid,
   output logic [INST_W-1:0] o_rsp_inst,
   output logic [ADDR_W-1:0] o_rsp_addr,
   output logic              o_rsp_oob,
`ifdef INST_PARITY_EN
   output logic              o_rsp_par_err,
`endif
   input  logic              i_load_en,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [INST_W-1:0] i_load_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
      $error("inst_mem_responder: LATENCY must be in 1..4");
   end
   if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_bad_depth
      $error("inst_mem_responder: DEPTH must be in 1..2**ADDR_W");
   end

   inst_t r_mem [DEPTH];
`ifdef INST_PARITY_EN
   logic  r_par [DEPTH];
`endif

   logic             r_ready;
   logic             w_accept;
   logic             w_req_in_range;
   logic             w_load_in_range;
   logic [IDX_W-1:0] w_req_idx;
   logic [IDX_W-1:0] w_load_idx;
   inst_t            w_rd_data;
   rsp_t             w_pipe_in;
   rsp_t             w_pipe_out;

   // ReqReady comes up on the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
      end
   end

   assign o_req_ready = r_ready && !i_load_en;
   assign w_accept    = i_req_valid && o_req_ready;

   // Unsigned compare at 32 bits so DEPTH = 2**ADDR_W needs no special case.
   assign w_req_in_range  = (32'(i_req_addr) < DEPTH);
   assign w_load_in_range = (32'(i_load_addr) < DEPTH);
   assign w_req_idx       = i_req_addr[IDX_W-1:0];
   assign w_load_idx      = i_load_addr[IDX_W-1:0];

   // Program store: write port only, never reset.
   always_ff @(posedge i_clk) begin
      if (i_load_en && w_load_in_range) begin
         r_mem[w_load_idx] <= i_load_data;
`ifdef INST_PARITY_EN
         r_par[w_load_idx] <= even_par(i_load_data);
`endif
      end
   end

   // Loads and accepts never share an edge, so the read sees a stable array.
   assign w_rd_data = r_mem[w_req_idx];

   always_comb begin
      w_pipe_in       = '0;
      w_pipe_in.valid = w_accept;
      w_pipe_in.addr  = i_req_addr;
      w_pipe_in.oob   = !w_req_in_range;
      w_pipe_in.inst  = w_req_in_range ? w_rd_data : NOP_INST;
`ifdef INST_PARITY_EN
      w_pipe_in.par_err = w_req_in_range && (even_par(w_rd_data) != r_par[w_req_idx]);
`endif
   end

   inst_mem_pipe #(
      .LATENCY (LATENCY)
   ) u_pipe (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_stage_in  (w_pipe_in),
      .o_stage_out (w_pipe_out)
   );

   assign o_rsp_valid = w_pipe_out.valid;
   assign o_rsp_inst  = w_pipe_out.inst;
   assign o_rsp_addr  = w_pipe_out.addr;
   assign o_rsp_oob   = w_pipe_out.oob;
`ifdef INST_PARITY_EN
   assign o_rsp_par_err = w_pipe_out.valid && w_pipe_out.par_err;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_inst_mem_responder
//   Scoreboard bench: the driver pushes expected responses (with the edge they
//   must appear after) into a queue; a negedge monitor pops and compares.
//   DUT built with DEPTH=512 so the upper half of the address space is out of range.
// ----------------------------------------------------------------------------
module tb_inst_mem_responder;

   localparam int unsigned DEPTH = 512;
   localparam int unsigned LAT   = 2;

   typedef struct {
      int         due;
      logic [9:0] addr;
      logic [8:0] inst;
      logic       oob;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [9:0] req_addr = '0;
   logic       flush = 1'b0;
   logic       rsp_valid;
   logic [8:0] rsp_inst;
   logic [9:0] rsp_addr;
   logic       rsp_oob;
   logic       load_en = 1'b0;
   logic [9:0] load_addr = '0;
   logic [8:0] load_data = '0;
`ifdef INST_PARITY_EN
   logic       rsp_par_err;
`endif

   inst_mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_addr    (req_addr),
      .i_flush       (flush),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_inst    (rsp_inst),
      .o_rsp_addr    (rsp_addr),
      .o_rsp_oob     (rsp_oob),
`ifdef INST_PARITY_EN
      .o_rsp_par_err (rsp_par_err),
`endif
      .i_load_en     (load_en),
      .i_load_addr   (load_addr),
      .i_load_data   (load_data)
   );

   always #5 clk = ~clk;

   int   edge_n = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   logic [8:0] mem_m [DEPTH];
   logic       exp_ready = 1'b0;
   logic [9:0] last_addr = '0;
   logic [8:0] last_inst = '0;
   logic       last_oob = 1'b0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h (edge %0d)", name, act, req, edge_n);
      end
   endtask

   // Monitor: compares outputs against the scoreboard on every negedge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("reset_ready", 32'(req_ready), 0);
         chk("reset_valid", 32'(rsp_valid), 0);
         chk("reset_inst", 32'(rsp_inst), 0);
         chk("reset_addr", 32'(rsp_addr), 0);
         chk("reset_oob", 32'(rsp_oob), 0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         if (rsp_valid) begin
            chk("rsp_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("rsp_timing", 32'(edge_n), 32'(e.due));
               chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
               chk("rsp_inst", 32'(rsp_inst), 32'(e.inst));
               chk("rsp_oob", 32'(rsp_oob), 32'(e.oob));
`ifdef INST_PARITY_EN
               chk("rsp_par_err", 32'(rsp_par_err), 0);
`endif
               last_addr = e.addr;
               last_inst = e.inst;
               last_oob  = e.oob;
            end
         end else begin
            chk("hold_addr", 32'(rsp_addr), 32'(last_addr));
            chk("hold_inst", 32'(rsp_inst), 32'(last_inst));
            chk("hold_oob", 32'(rsp_oob), 32'(last_oob));
            chk("rsp_missing", 32'(q.size() > 0 && q[0].due <= edge_n), 0);
            if (q.size() > 0 && q[0].due <= edge_n) void'(q.pop_front());
         end
      end
   end

   // One cycle of stimulus; the model decides accept/flush/write from the rules.
   task automatic step(input logic v, input logic [9:0] a, input logic fl,
                       input logic le, input logic [9:0] la, input logic [8:0] ld);
      exp_t e;
      int   f;
      @(posedge clk);
      #1;
      req_valid = v;
      req_addr  = a;
      flush     = fl;
      load_en   = le;
      load_addr = la;
      load_data = ld;
      exp_ready = !le;
      f = edge_n + 1;
      if (fl) begin
         while (q.size() > 0 && q[$].due >= f) void'(q.pop_back());
      end
      if (v && !le) begin
         e.due  = f + int'(LAT) - 1;
         e.addr = a;
         e.oob  = (int'(a) >= int'(DEPTH));
         e.inst = e.oob ? 9'h000 : mem_m[int'(a)];
         q.push_back(e);
      end
      if (le && int'(la) < int'(DEPTH)) mem_m[int'(la)] = ld;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 9'h0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      load_en   = 1'b0;
      rst_n     = 1'b0;
      exp_ready = 1'b0;
      q.delete();
      last_addr = '0;
      last_inst = '0;
      last_oob  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       v, fl, le;
      logic [9:0] a, la;
      logic [8:0] ld;

      // Reset held over three edges, released; ready stays low for one more cycle.
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 10'h0, 1'b0, 1'b1, 10'(i), 9'($urandom));

      // Back-to-back fetches of freshly loaded words.
      step(1'b0, 10'h0, 1'b0, 1'b1, 10'h005, 9'h1A3);
      step(1'b0, 10'h0, 1'b0, 1'b1, 10'h006, 9'h0F0);
      step(1'b1, 10'h005, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h006, 1'b0, 1'b0, 10'h0, 9'h0);
      idle(3);

      // Streaming then flush with the branch target accepted in the same cycle.
      step(1'b1, 10'h005, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h006, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h007, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h008, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h020, 1'b1, 1'b0, 10'h0, 9'h0);
      idle(3);

      // Out of range: NOP + oob; load to an out-of-range address has no effect.
      step(1'b1, 10'h3FF, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b0, 10'h0, 1'b0, 1'b1, 10'h3FF, 9'h155);
      step(1'b1, 10'h3FF, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h200, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h1FF, 1'b0, 1'b0, 10'h0, 9'h0);
      idle(3);

      // Load blocks accept; in-flight read of the same word keeps old data.
      step(1'b1, 10'h010, 1'b0, 1'b1, 10'h010, 9'h0AA);
      step(1'b1, 10'h011, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b0, 10'h0, 1'b0, 1'b1, 10'h011, 9'h1C4);
      step(1'b1, 10'h011, 1'b0, 1'b0, 10'h0, 9'h0);
      step(1'b1, 10'h010, 1'b0, 1'b0, 10'h0, 9'h0);
      idle(3);

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            do_reset(2);
         end else begin
            v  = ($urandom_range(3) != 0);
            a  = ($urandom_range(7) == 0) ? 10'(512 + $urandom_range(511))
                                          : 10'($urandom_range(511));
            fl = ($urandom_range(15) == 0);
            le = ($urandom_range(7) == 0);
            la = 10'($urandom_range(1023));
            ld = 9'($urandom);
            step(v, a, fl, le, la, ld);
         end
      end

      idle(LAT + 4);
      @(negedge clk);
      chk("drain_empty", 32'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
